// File: rtl/issue_instr_info_store.sv
// Per-wavefront decoded-instruction info store: one info word plus valid bit per slot,
// multi-port combinational read with optional decode write-through, occupancy and overwrite tracking.
module issue_instr_info_store #(
  parameter int                NUM_WF      = 40,
  parameter int                WF_ID_W     = 6,
  parameter int                INFO_W      = 48,
  parameter int                NUM_RD      = 6,
  parameter logic [NUM_RD-1:0] BYPASS_MASK = 6'b001111,
  parameter int                CNT_W       = $clog2(NUM_WF + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        f_decode_valid,
  input  logic [WF_ID_W-1:0]          f_decode_wfid,
  input  logic [INFO_W-1:0]           decode_wr_data,
  input  logic                        clr_valid,
  input  logic [WF_ID_W-1:0]          clr_wfid,
  input  logic [NUM_RD*WF_ID_W-1:0]   rd_wfid,
  output logic [NUM_RD*INFO_W-1:0]    rd_data,
  output logic [NUM_RD-1:0]           rd_vld,
  output logic [CNT_W-1:0]            occupancy,
  output logic                        full,
  output logic                        empty,
  output logic                        overwrite_err,
  output logic [WF_ID_W-1:0]          overwrite_wfid
);

  localparam logic [WF_ID_W:0] NUM_WF_X = (WF_ID_W + 1)'(NUM_WF);

  logic [INFO_W-1:0]  data_q [NUM_WF];
  logic [NUM_WF-1:0]  valid_q;
  logic [CNT_W-1:0]   occ_q;
  logic               err_q;
  logic [WF_ID_W-1:0] err_wfid_q;

  logic               wr_legal;
  logic               clr_legal;
  logic               same_slot;
  logic [NUM_WF-1:0]  wr_hit;
  logic [NUM_WF-1:0]  clr_hit;
  logic               wr_to_valid;
  logic               clr_to_valid;
  logic               inc;
  logic               dec;
  logic               err_set;
  logic [WF_ID_W-1:0] rd_addr [NUM_RD];

  assign wr_legal  = f_decode_valid && ({1'b0, f_decode_wfid} < NUM_WF_X);
  assign clr_legal = clr_valid && ({1'b0, clr_wfid} < NUM_WF_X);
  assign same_slot = wr_legal && clr_legal && (f_decode_wfid == clr_wfid);

  always_comb begin
    wr_hit  = '0;
    clr_hit = '0;
    for (int e = 0; e < NUM_WF; e++) begin
      wr_hit[e]  = wr_legal && (f_decode_wfid == WF_ID_W'(e));
      clr_hit[e] = clr_legal && (clr_wfid == WF_ID_W'(e));
    end
  end

  assign wr_to_valid  = |(wr_hit & valid_q);
  assign clr_to_valid = |(clr_hit & valid_q);

  // A same-slot write overrides the clear, so the clear never decrements nor masks the write.
  assign inc     = wr_legal && !wr_to_valid;
  assign dec     = clr_to_valid && !same_slot;
  assign err_set = wr_legal && wr_to_valid && !same_slot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NUM_WF; e++) data_q[e] <= '0;
      valid_q    <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
      err_wfid_q <= '0;
    end else begin
      for (int e = 0; e < NUM_WF; e++) begin
        if (wr_hit[e]) data_q[e] <= decode_wr_data;
      end
      valid_q <= (valid_q & ~clr_hit) | wr_hit;
      occ_q   <= occ_q + CNT_W'(inc) - CNT_W'(dec);
      if (err_set && !err_q) begin
        err_q      <= 1'b1;
        err_wfid_q <= f_decode_wfid;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_addr
    assign rd_addr[p] = rd_wfid[p*WF_ID_W +: WF_ID_W];
  end

  // Out-of-range addresses match no entry and fall through to zero; clears are never bypassed.
  always_comb begin
    rd_data = '0;
    rd_vld  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int e = 0; e < NUM_WF; e++) begin
        if (rd_addr[p] == WF_ID_W'(e)) begin
          rd_data[p*INFO_W +: INFO_W] = data_q[e];
          rd_vld[p]                   = valid_q[e];
        end
      end
      if (BYPASS_MASK[p] && wr_legal && (f_decode_wfid == rd_addr[p])) begin
        rd_data[p*INFO_W +: INFO_W] = decode_wr_data;
        rd_vld[p]                   = 1'b1;
      end
    end
  end

  assign occupancy      = occ_q;
  assign full           = (occ_q == CNT_W'(NUM_WF));
  assign empty          = (occ_q == '0);
  assign overwrite_err  = err_q;
  assign overwrite_wfid = err_wfid_q;

endmodule

// File: tb/tb_issue_instr_info_store.sv
// Randomised and directed bench for issue_instr_info_store against an array-based reference model.
module tb_issue_instr_info_store;

  localparam int                NUM_WF      = 40;
  localparam int                WF_ID_W     = 6;
  localparam int                INFO_W      = 48;
  localparam int                NUM_RD      = 6;
  localparam logic [NUM_RD-1:0] BYPASS_MASK = 6'b001111;
  localparam int                CNT_W       = $clog2(NUM_WF + 1);

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        f_decode_valid;
  logic [WF_ID_W-1:0]          f_decode_wfid;
  logic [INFO_W-1:0]           decode_wr_data;
  logic                        clr_valid;
  logic [WF_ID_W-1:0]          clr_wfid;
  logic [NUM_RD*WF_ID_W-1:0]   rd_wfid;
  logic [NUM_RD*INFO_W-1:0]    rd_data;
  logic [NUM_RD-1:0]           rd_vld;
  logic [CNT_W-1:0]            occupancy;
  logic                        full;
  logic                        empty;
  logic                        overwrite_err;
  logic [WF_ID_W-1:0]          overwrite_wfid;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [INFO_W-1:0] m_data  [NUM_WF];
  logic              m_valid [NUM_WF];
  logic              m_err;
  int                m_errid;

  always #5 clk = ~clk;

  issue_instr_info_store #(
    .NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .INFO_W(INFO_W),
    .NUM_RD(NUM_RD), .BYPASS_MASK(BYPASS_MASK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .f_decode_valid(f_decode_valid), .f_decode_wfid(f_decode_wfid),
    .decode_wr_data(decode_wr_data),
    .clr_valid(clr_valid), .clr_wfid(clr_wfid),
    .rd_wfid(rd_wfid), .rd_data(rd_data), .rd_vld(rd_vld),
    .occupancy(occupancy), .full(full), .empty(empty),
    .overwrite_err(overwrite_err), .overwrite_wfid(overwrite_wfid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    for (int e = 0; e < NUM_WF; e++) if (m_valid[e]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < NUM_WF; e++) begin
      m_data[e]  = '0;
      m_valid[e] = 1'b0;
    end
    m_err   = 1'b0;
    m_errid = 0;
  endtask

  task automatic check_outputs();
    int a;
    logic [INFO_W-1:0] ed;
    logic              ev;
    int occ;
    for (int p = 0; p < NUM_RD; p++) begin
      a = int'(rd_wfid[p*WF_ID_W +: WF_ID_W]);
      if (a >= NUM_WF) begin
        ed = '0; ev = 1'b0;
      end else if (BYPASS_MASK[p] && f_decode_valid && int'(f_decode_wfid) == a) begin
        ed = decode_wr_data; ev = 1'b1;
      end else begin
        ed = m_data[a]; ev = m_valid[a];
      end
      check($sformatf("rd_data%0d", p), 64'(rd_data[p*INFO_W +: INFO_W]), 64'(ed));
      check($sformatf("rd_vld%0d", p), 64'(rd_vld[p]), 64'(ev));
    end
    occ = model_occ();
    check("occupancy", 64'(occupancy), 64'(occ));
    check("full", 64'(full), 64'(occ == NUM_WF));
    check("empty", 64'(empty), 64'(occ == 0));
    check("overwrite_err", 64'(overwrite_err), 64'(m_err));
    check("overwrite_wfid", 64'(overwrite_wfid), 64'(m_errid));
  endtask

  task automatic model_update();
    int  dw = int'(f_decode_wfid);
    int  cw = int'(clr_wfid);
    bit  wl = f_decode_valid && dw < NUM_WF;
    bit  cl = clr_valid && cw < NUM_WF;
    if (wl && m_valid[dw] && !(cl && cw == dw) && !m_err) begin
      m_err   = 1'b1;
      m_errid = dw;
    end
    if (cl) m_valid[cw] = 1'b0;
    if (wl) begin
      m_data[dw]  = decode_wr_data;
      m_valid[dw] = 1'b1;
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, then advance model at the edge.
  task automatic cycle(input bit dv, input int dw, input logic [INFO_W-1:0] wd,
                       input bit cv, input int cw);
    f_decode_valid = dv;
    f_decode_wfid  = WF_ID_W'(dw);
    decode_wr_data = wd;
    clr_valid      = cv;
    clr_wfid       = WF_ID_W'(cw);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_all_rd(input int a);
    for (int p = 0; p < NUM_RD; p++) rd_wfid[p*WF_ID_W +: WF_ID_W] = WF_ID_W'(a);
  endtask

  task automatic apply_reset();
    f_decode_valid = 1'b0;
    clr_valid      = 1'b0;
    rst            = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    f_decode_valid = 1'b0;
    f_decode_wfid  = '0;
    decode_wr_data = '0;
    clr_valid      = 1'b0;
    clr_wfid       = '0;
    rd_wfid        = '0;
    apply_reset();

    // Write slot 5; port 0 bypasses, port 4 does not
    set_all_rd(5);
    cycle(1, 5, 48'hABCD, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("slot5_p4_data", 64'(rd_data[4*INFO_W +: INFO_W]), 64'hABCD);
    check("slot5_occ", 64'(occupancy), 64'd1);

    // Fill every slot, then retire slot 39
    apply_reset();
    set_all_rd(39);
    for (int i = 0; i < NUM_WF; i++) cycle(1, i, INFO_W'(48'h100 + i), 0, 0);
    check("fill_full", 64'(full), 64'd1);
    cycle(0, 0, 0, 1, 39);
    check("clr39_occ", 64'(occupancy), 64'd39);
    check("clr39_data", 64'(rd_data[5*INFO_W +: INFO_W]), 64'h100 + 64'd39);
    check("clr39_vld", 64'(rd_vld[5]), 64'd0);

    // Same-slot write and clear: write wins, no error
    set_all_rd(7);
    cycle(1, 7, 48'h1, 1, 7);
    cycle(0, 0, 0, 0, 0);
    check("wc7_err", 64'(overwrite_err), 64'd0);
    check("wc7_occ", 64'(occupancy), 64'd39);

    // Overwrite error capture and stickiness
    apply_reset();
    set_all_rd(3);
    cycle(1, 3, 48'h11, 0, 0);
    cycle(1, 3, 48'h22, 0, 0);
    check("ow_err", 64'(overwrite_err), 64'd1);
    check("ow_wfid", 64'(overwrite_wfid), 64'd3);
    cycle(1, 9, 48'h33, 0, 0);
    cycle(1, 9, 48'h44, 0, 0);
    check("ow_wfid_sticky", 64'(overwrite_wfid), 64'd3);

    // Out-of-range slot
    set_all_rd(45);
    cycle(1, 45, 48'hDEAD, 1, 45);
    cycle(0, 0, 0, 0, 0);
    check("oor_occ", 64'(occupancy), 64'd2);

    // Asynchronous reset mid-fill
    apply_reset();
    for (int i = 0; i < 12; i++) cycle(1, i, INFO_W'({$urandom, $urandom}), 0, 0);
    check("midfill_occ", 64'(occupancy), 64'd12);
    set_all_rd(2);
    apply_reset();

    // Random traffic with one reset in the middle
    for (int n = 0; n < 2000; n++) begin
      int dw, cw;
      dw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
      cw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
      if ($urandom_range(0, 3) == 0) cw = dw;
      for (int p = 0; p < NUM_RD; p++)
        rd_wfid[p*WF_ID_W +: WF_ID_W] = ($urandom_range(0, 2) == 0) ? WF_ID_W'(dw)
                                                                     : WF_ID_W'($urandom_range(0, 63));
      if (n == 1000) apply_reset();
      cycle($urandom_range(0, 1) == 1, dw, INFO_W'({$urandom, $urandom}),
            $urandom_range(0, 9) < 4, cw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_instr_info_store.md
# issue_instr_info_store

Parametrised per-wavefront instruction-info store for the issue stage. Holds one decoded-instruction info word per wavefront slot, written by decode and read by a configurable number of completion and issue ports, with per-port decode write-through bypass. Adds per-entry valid tracking with an explicit retire/clear port, an occupancy counter with full/empty flags, and sticky overwrite-error detection.

## Interface
- NUM_WF, 40, number of wavefront slots (entries)
- WF_ID_W, 6, wavefront-id width; NUM_WF <= 2**WF_ID_W
- INFO_W, 48, info word width
- NUM_RD, 6, number of read ports
- BYPASS_MASK, 6'b001111, bit i = 1 enables decode write-through on read port i
- CNT_W, $clog2(NUM_WF+1), occupancy counter width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- f_decode_valid  in  1  write strobe from decode
- f_decode_wfid  in  WF_ID_W  write slot
- decode_wr_data  in  INFO_W  write data
- clr_valid  in  1  retire strobe; invalidates an entry
- clr_wfid  in  WF_ID_W  slot to invalidate
- rd_wfid  in  NUM_RD*WF_ID_W  packed read addresses; port i at [i*WF_ID_W +: WF_ID_W]
- rd_data  out  NUM_RD*INFO_W  packed read data, same packing
- rd_vld  out  NUM_RD  per-port entry-valid
- occupancy  out  CNT_W  number of valid entries
- full  out  1  occupancy == NUM_WF
- empty  out  1  occupancy == 0
- overwrite_err  out  1  sticky: write hit an already-valid entry not retiring that cycle
- overwrite_wfid  out  WF_ID_W  slot of the first overwrite error

## Operation
- State: data[NUM_WF] (INFO_W each), valid[NUM_WF], occupancy, overwrite_err, overwrite_wfid.
- Write (f_decode_valid=1, f_decode_wfid < NUM_WF): data[wfid] <= decode_wr_data; valid[wfid] <= 1.
- Clear (clr_valid=1, clr_wfid < NUM_WF): valid[clr_wfid] <= 0; data untouched.
- Write and clear to same slot in same cycle: write wins; entry valid with new data; no error.
- Write/clear with wfid >= NUM_WF: ignored; no state change, no error.
- Clear of an invalid entry: no-op.
- Occupancy next = occupancy + inc - dec; inc = 1 iff a legal write targets an invalid entry; dec = 1 iff a legal clear targets a valid entry AND is not overridden by a same-slot write. Counter never wraps; by construction stays in 0..NUM_WF.
- Overwrite error: legal write to valid entry, not cleared same cycle -> data still overwritten, occupancy unchanged; if overwrite_err=0, set it and capture overwrite_wfid. Subsequent errors do not update overwrite_wfid. Cleared only by reset.
- Read port i (combinational): if rd_wfid_i >= NUM_WF -> rd_data_i = 0, rd_vld_i = 0. Else if BYPASS_MASK[i] and f_decode_valid and f_decode_wfid == rd_wfid_i -> rd_data_i = decode_wr_data, rd_vld_i = 1. Else rd_data_i = data[rd_wfid_i], rd_vld_i = valid[rd_wfid_i].
- Clear is never bypassed: same-cycle clear still reads old valid=1.
- full/empty are combinational decodes of the occupancy register.

## Timing
- Reset (rst=0, async): data all 0, valid all 0, occupancy 0, empty 1, full 0, overwrite_err 0, overwrite_wfid 0; rd_data/rd_vld read 0 for non-bypassed ports.
- Reset release synchronous to first rising clk edge with rst=1; assertion mid-operation discards in-flight write/clear.
- Write/clear take effect at the next rising edge; visible on non-bypassed ports 1 cycle later, on bypassed ports in the same cycle.
- Read latency 0 cycles; no handshake, no back-pressure; all ports independent, any number may address the same slot.
- occupancy/full/empty/overwrite_err update 1 cycle after the causing edge input.

## Test plan
- Reset then write slot 5 = 0xABCD: same cycle port 0 (bypass) returns 0xABCD vld=1, port 4 (no bypass) returns 0 vld=0; next cycle both 0xABCD vld=1, occupancy=1, empty=0.
- Fill all 40 slots one per cycle -> occupancy 40, full=1 after last edge; clear slot 39 -> occupancy 39, full=0, port reads slot 39 data unchanged, vld=0.
- Same cycle write slot 7 = 0x1 and clear slot 7 (slot 7 previously valid) -> slot 7 valid, data 0x1, occupancy unchanged, overwrite_err=0.
- Write slot 3 twice without clear (0x11 then 0x22) -> overwrite_err=1, overwrite_wfid=3, data 0x22, occupancy 1; later overwrite on slot 9 keeps overwrite_wfid=3.
- Write/clear/read with wfid 45 (>= NUM_WF) -> no state change, rd_data=0, rd_vld=0.
- Assert rst mid-fill (occupancy 12) -> all outputs return to reset values immediately, without a clock edge.
